// File: rtl/counter_run_ctrl_if.sv
// Bus between counter_run_ctrl and its environment: requesters plus the shared counter.
// master = requesters/counter side, slave = the run controller.
// The abort wire exists only when CNT_CTRL_ABORT_EN is defined.
interface counter_run_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] tc;
  logic [WIDTH-1:0]      cnt_val;
  logic                  cnt_rst;
  logic                  cnt_en;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
`ifdef CNT_CTRL_ABORT_EN
  logic                  abort;

  modport master (output req, tc, cnt_val, abort,
                  input  cnt_rst, cnt_en, gnt, done, busy);
  modport slave  (input  req, tc, cnt_val, abort,
                  output cnt_rst, cnt_en, gnt, done, busy);
`else
  modport master (output req, tc, cnt_val,
                  input  cnt_rst, cnt_en, gnt, done, busy);
  modport slave  (input  req, tc, cnt_val,
                  output cnt_rst, cnt_en, gnt, done, busy);
`endif
endinterface

// File: rtl/counter_run_ctrl.sv
// Purpose: non-preemptive round-robin owner of one shared WIDTH-bit up-counter (clear, run to tc, done).
// Latency: 1 cycle from req in IDLE to gnt; gnt to done pulse is tc+2 cycles.
// Backpressure: none; req is a level held until own done, a granted run always finishes.
// Optional feature: define CNT_CTRL_ABORT_EN to add an abort input that cancels CLEAR/RUN.
module counter_run_ctrl #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  counter_run_ctrl_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [IW-1:0]    ptr;        // first requester considered at next arbitration
  logic [IW-1:0]    g;          // index of the requester owning the counter
  logic [WIDTH-1:0] tc_lat;     // terminal count frozen at grant time
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;
  logic             cnt_rst_q;

  logic             any_req;
  logic [IW-1:0]    pick;
  logic             at_tc;
  logic             abort_in;
  logic [WIDTH-1:0] tc_arr [NREQ];

  // (base + off) mod NREQ; base is always a valid index so one subtraction suffices
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_tc
    assign tc_arr[i] = bus.tc[i*WIDTH +: WIDTH];
  end

`ifdef CNT_CTRL_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  // Round-robin pick: scan offsets high to low so the lowest offset from ptr wins
  always_comb begin
    any_req = 1'b0;
    pick    = ptr;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (bus.req[wrap_add(ptr, off)]) begin
        any_req = 1'b1;
        pick    = wrap_add(ptr, off);
      end
    end
  end

  // Full-width unsigned compare; the counter is stopped here so it never wraps
  assign at_tc = (bus.cnt_val == tc_lat);

  // Controller FSM with registered Moore outputs; reset drops everything without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      g         <= '0;
      tc_lat    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      cnt_rst_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= CLEAR;
            g         <= pick;
            tc_lat    <= tc_arr[pick];
            gnt_q     <= onehot(pick);
            busy_q    <= 1'b1;
            cnt_rst_q <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_rst_q <= 1'b0;
          if (abort_in) begin
            state  <= IDLE;
            gnt_q  <= '0;
            busy_q <= 1'b0;
            ptr    <= wrap_add(g, 1);
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort_in) begin
            state  <= IDLE;
            gnt_q  <= '0;
            busy_q <= 1'b0;
            ptr    <= wrap_add(g, 1);
          end else if (at_tc) begin
            state  <= DONE;
            done_q <= onehot(g);
          end
        end
        DONE: begin
          // Advancing past g lets a waiting peer win over g re-requesting
          state  <= IDLE;
          gnt_q  <= '0;
          done_q <= '0;
          busy_q <= 1'b0;
          ptr    <= wrap_add(g, 1);
        end
        default: begin
          state     <= IDLE;
          gnt_q     <= '0;
          done_q    <= '0;
          busy_q    <= 1'b0;
          cnt_rst_q <= 1'b0;
        end
      endcase
    end
  end

  // cnt_en is the one combinational output: it must fall in the same cycle cnt_val hits tc
  assign bus.cnt_en  = (state == RUN) && !at_tc;
  assign bus.cnt_rst = cnt_rst_q;
  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

`ifndef SYNTHESIS
  a_gnt_done_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q) && ((done_q & ~gnt_q) == '0));
`endif

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: directed scenarios then randomized requesters and terminal counts.
// A transaction-level model (grant, phase counter since grant) predicts every output each cycle.
// The controlled counter is modelled here and driven by the DUT's cnt_rst/cnt_en.
module tb_counter_run_ctrl;

  localparam int W = 4;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]   req_v;
  logic [N*W-1:0] tc_v;
  logic [W-1:0]   cnt_q = '0;
`ifdef CNT_CTRL_ABORT_EN
  logic abort_v;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: run owner, phase k = edges since grant, latched tc, rr pointer, counter value
  bit m_act;
  int m_g, m_k, m_tcl, m_ptr, m_cnt;

  // observation of DUT grant timing
  int cyc = 0;
  int gnt_cyc = 0;
  int last_lat = -1;
  bit prev_gnt = 1'b0;
  int gnt_log[$];

  counter_run_ctrl_if #(.WIDTH(W), .NREQ(N)) bus ();

  counter_run_ctrl #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.req     = req_v;
  assign bus.tc      = tc_v;
  assign bus.cnt_val = cnt_q;
`ifdef CNT_CTRL_ABORT_EN
  assign bus.abort   = abort_v;
`endif

  always #5 clk = ~clk;

  // the shared counter under control
  always @(posedge clk) begin
    if (bus.cnt_rst)     cnt_q <= '0;
    else if (bus.cnt_en) cnt_q <= cnt_q + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_gnt();  return m_act ? (1 << m_g) : 0; endfunction
  function automatic int exp_done(); return (m_act && m_k == m_tcl + 2) ? (1 << m_g) : 0; endfunction
  function automatic bit exp_rst();  return m_act && m_k == 0; endfunction
  function automatic bit exp_en();   return m_act && m_k >= 1 && m_k <= m_tcl; endfunction

  task automatic model_reset();
    m_act = 1'b0; m_g = 0; m_k = 0; m_tcl = 0; m_ptr = 0;
    prev_gnt = 1'b0;
  endtask

  // one clock edge: advance model from pre-edge inputs, then compare all outputs
  task automatic step();
    bit en_pre, rst_pre, stop;
    int idx;
    en_pre  = exp_en();
    rst_pre = exp_rst();
    @(posedge clk);
    cyc++;
    if (rst_pre)     m_cnt = 0;
    else if (en_pre) m_cnt = (m_cnt + 1) % (1 << W);
    if (m_act) begin
      stop = (m_k == m_tcl + 2);
`ifdef CNT_CTRL_ABORT_EN
      if (abort_v && m_k <= m_tcl + 1) stop = 1'b1;
`endif
      if (stop) begin
        m_act = 1'b0;
        m_ptr = (m_g + 1) % N;
      end else begin
        m_k++;
      end
    end else begin
      for (int off = 0; off < N; off++) begin
        idx = (m_ptr + off) % N;
        if (req_v[idx]) begin
          m_act = 1'b1; m_g = idx; m_k = 0;
          m_tcl = int'(tc_v[idx*W +: W]);
          break;
        end
      end
    end
    #1;
    chk("gnt",     32'(bus.gnt),     exp_gnt());
    chk("done",    32'(bus.done),    exp_done());
    chk("busy",    32'(bus.busy),    32'(m_act));
    chk("cnt_rst", 32'(bus.cnt_rst), 32'(exp_rst()));
    chk("cnt_en",  32'(bus.cnt_en),  32'(exp_en()));
    chk("cnt_val", 32'(cnt_q),       m_cnt);
    if (bus.gnt != '0 && !prev_gnt) begin
      gnt_cyc = cyc;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) gnt_log.push_back(i);
    end
    if (bus.done != '0) last_lat = cyc - gnt_cyc;
    prev_gnt = (bus.gnt != '0);
  endtask

  task automatic run_phase(input logic [N-1:0] r, input logic [N*W-1:0] t, input int n);
    req_v = r;
    tc_v  = t;
    repeat (n) step();
  endtask

  // asynchronous reset mid-cycle: outputs must drop before any clock edge
  task automatic arst_pulse();
    rst_n = 1'b0;
    #1;
    chk("arst_gnt",     32'(bus.gnt),     0);
    chk("arst_busy",    32'(bus.busy),    0);
    chk("arst_cnt_en",  32'(bus.cnt_en),  0);
    chk("arst_done",    32'(bus.done),    0);
    chk("arst_cnt_rst", 32'(bus.cnt_rst), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req_v = '0;
    tc_v  = '0;
`ifdef CNT_CTRL_ABORT_EN
    abort_v = 1'b0;
`endif
    model_reset();
    m_cnt = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt",     32'(bus.gnt),     0);
    chk("rst_done",    32'(bus.done),    0);
    chk("rst_busy",    32'(bus.busy),    0);
    chk("rst_cnt_rst", 32'(bus.cnt_rst), 0);
    chk("rst_cnt_en",  32'(bus.cnt_en),  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // requester 0, tc=5: seven cycles grant to done
    run_phase(2'b01, {4'h0, 4'h5}, 9);
    run_phase(2'b00, {4'h0, 4'h5}, 3);
    chk("lat_tc5", last_lat, 7);

    // tc=0: run of one cycle, no enable
    run_phase(2'b01, {4'h0, 4'h0}, 4);
    run_phase(2'b00, {4'h0, 4'h0}, 3);
    chk("lat_tc0", last_lat, 2);

    // both requesting from reset: strict alternation starting at 0
    arst_pulse();
    gnt_log.delete();
    run_phase(2'b11, {4'h4, 4'h3}, 32);
    run_phase(2'b00, {4'h4, 4'h3}, 8);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order%0d", i), (i < gnt_log.size()) ? gnt_log[i] : 99, i % 2);

    // full-range tc on requester 1: counter stops at all-ones
    run_phase(2'b10, {4'hF, 4'h0}, 19);
    run_phase(2'b00, {4'hF, 4'h0}, 5);
    chk("hold_F", 32'(cnt_q), 15);

    // reset in RUN at cnt_val=2, then a fresh full run with req held
    req_v = 2'b01;
    tc_v  = {4'h0, 4'h6};
    for (int i = 0; i < 12; i++) begin
      step();
      if (m_act && m_k == 3) break;
    end
    chk("arst_reach_cnt2", 32'(cnt_q), 2);
    arst_pulse();
    run_phase(2'b01, {4'h0, 4'h6}, 9);
    chk("lat_after_arst", last_lat, 8);
    run_phase(2'b00, {4'h0, 4'h6}, 10);

    // randomized requesters: hold until own done, occasional mid-run drops, tc churns every cycle
    for (int c = 0; c < 3000; c++) begin
      tc_v = (N*W)'($urandom);
`ifdef CNT_CTRL_ABORT_EN
      abort_v = ($urandom_range(31) == 0);
`endif
      for (int i = 0; i < N; i++) begin
        if (!req_v[i]) begin
          if ($urandom_range(3) == 0) req_v[i] = 1'b1;
        end else if (m_act && m_g == i) begin
          if (exp_done() != 0) begin
            if ($urandom_range(1) == 0) req_v[i] = 1'b0;
          end else if ($urandom_range(15) == 0) begin
            req_v[i] = 1'b0;
          end
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
